// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus: requester ports plus the shared memory port.
// The slave view is the arbiter itself; the master view is its surroundings.
interface mem_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters one outstanding access at a time
// to a shared memory port, with a response timeout.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input logic          clk_i,
    input logic          arst_i,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [15:0] LIMIT = 16'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        owner_q;
    logic        last_q, last_d;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;

    logic any_req;
    logic win;
    logic timeout;
    logic gnt;
    logic rvalid;
    logic err;

    assign any_req = bus.m0_req_i | bus.m1_req_i;
    // On a tie the requester not served last wins
    assign win = (bus.m0_req_i & bus.m1_req_i) ? ~last_q : bus.m1_req_i;
    assign timeout = (cnt_q == LIMIT);

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        gnt             = 1'b0;
        rvalid          = 1'b0;
        err             = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'd0;
        bus.mem_addr_o  = 32'd0;
        bus.mem_wdata_o = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = REQ;
            end
            REQ: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_be_o    = be_q;
                bus.mem_addr_o  = addr_q;
                bus.mem_wdata_o = wdata_q;
                if (timeout) begin
                    err     = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (bus.mem_gnt_i) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // A response landing on the timeout cycle still completes
                if (bus.mem_rvalid_i) begin
                    rvalid  = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (timeout) begin
                    err     = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m0_gnt_o    = gnt & ~owner_q;
        bus.m1_gnt_o    = gnt & owner_q;
        bus.m0_rvalid_o = rvalid & ~owner_q;
        bus.m1_rvalid_o = rvalid & owner_q;
        bus.m0_err_o    = err & ~owner_q;
        bus.m1_err_o    = err & owner_q;
        bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.mem_rdata_i : 32'd0;
        bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.mem_rdata_i : 32'd0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (state_q == IDLE) begin
                if (any_req) begin
                    owner_q <= win;
                    we_q    <= win ? bus.m1_we_i    : bus.m0_we_i;
                    be_q    <= win ? bus.m1_be_i    : bus.m0_be_i;
                    addr_q  <= win ? bus.m1_addr_i  : bus.m0_addr_i;
                    wdata_q <= win ? bus.m1_wdata_i : bus.m0_wdata_i;
                    cnt_q   <= 16'd0;
                end
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: handshake, round-robin, stall,
// timeout, reset abort and completion-vs-timeout priority.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_WAIT(8)) dut (
        .clk_i (clk),
        .arst_i(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_be_i = 0;
        bus.m0_addr_i = 0; bus.m0_wdata_i = 0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_be_i = 0;
        bus.m1_addr_i = 0; bus.m1_wdata_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    int          ngnt;
    logic        own [4];
    logic [31:0] adr [4];

    initial begin
        clear_inputs();
        step(); #1;
        check("rst_mem_req", 32'(bus.mem_req_o), 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_gnt", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 0);
        check("rst_rv_err", 32'({bus.m0_rvalid_o, bus.m1_rvalid_o,
                                 bus.m0_err_o, bus.m1_err_o}), 0);
        step();
        rst = 1'b0;

        // Basic read by m0
        bus.m0_req_i = 1; bus.m0_be_i = 4'hf; bus.m0_addr_i = 32'h100;
        #1 check("r_idle_req", 32'(bus.mem_req_o), 0);
        step();
        bus.m0_req_i = 0; bus.m0_addr_i = 0; bus.mem_gnt_i = 1;
        #1 check("r_req", 32'(bus.mem_req_o), 1);
        check("r_addr", bus.mem_addr_o, 32'h100);
        check("r_we", 32'(bus.mem_we_o), 0);
        check("r_gnt0", 32'(bus.m0_gnt_o), 1);
        check("r_gnt1", 32'(bus.m1_gnt_o), 0);
        step();
        bus.mem_gnt_i = 0;
        #1 check("r_resp_req", 32'(bus.mem_req_o), 0);
        check("r_resp_addr", bus.mem_addr_o, 0);
        check("r_resp_gnt", 32'(bus.m0_gnt_o), 0);
        check("r_early_rv", 32'(bus.m0_rvalid_o), 0);
        step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
        #1 check("r_rv0", 32'(bus.m0_rvalid_o), 1);
        check("r_rdata0", bus.m0_rdata_o, 32'hDEADBEEF);
        check("r_rv1", 32'(bus.m1_rvalid_o), 0);
        check("r_rdata1", bus.m1_rdata_o, 0);
        step();
        bus.mem_rvalid_i = 0;
        #1 check("r_after_rv", 32'(bus.m0_rvalid_o), 0);
        check("r_after_rdata", bus.m0_rdata_o, 0);

        // Round-robin with both requesting from reset
        do_reset();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'hA0;
        bus.m1_req_i = 1; bus.m1_addr_i = 32'hB0;
        bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1;
        ngnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(); #1;
            if ((bus.m0_gnt_o | bus.m1_gnt_o) && ngnt < 4) begin
                own[ngnt] = bus.m1_gnt_o;
                adr[ngnt] = bus.mem_addr_o;
                ngnt++;
            end
        end
        check("rr_count", 32'(ngnt), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_owner%0d", i), 32'(own[i]), 32'(i % 2));
            check($sformatf("rr_addr%0d", i), adr[i],
                  (i % 2) ? 32'hB0 : 32'hA0);
        end

        // m1 write with gnt withheld three cycles
        do_reset();
        bus.m1_req_i = 1; bus.m1_we_i = 1; bus.m1_be_i = 4'b1100;
        bus.m1_addr_i = 32'h200; bus.m1_wdata_i = 32'h12345678;
        ngnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.m1_req_i = 0; bus.m1_addr_i = 32'hFFF; bus.m1_wdata_i = 0;
            bus.m1_be_i = 0; bus.m1_we_i = 0;
            bus.mem_gnt_i = (i == 3);
            #1 check($sformatf("w_req%0d", i), 32'(bus.mem_req_o), 1);
            check($sformatf("w_fields%0d", i),
                  {bus.mem_addr_o[23:0], 3'b0, bus.mem_we_o, bus.mem_be_o},
                  {24'h000200, 3'b0, 1'b1, 4'b1100});
            check($sformatf("w_wdata%0d", i), bus.mem_wdata_o, 32'h12345678);
            if (bus.m1_gnt_o) ngnt++;
            check($sformatf("w_gnt0_%0d", i), 32'(bus.m0_gnt_o), 0);
        end
        check("w_gnt1_count", 32'(ngnt), 1);
        step();
        bus.mem_gnt_i = 0;
        #1 check("w_resp_req", 32'(bus.mem_req_o), 0);
        check("w_resp_gnt", 32'(bus.m1_gnt_o), 0);
        step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h55;
        #1 check("w_rv1", 32'(bus.m1_rvalid_o), 1);
        check("w_rdata1", bus.m1_rdata_o, 32'h55);
        check("w_rdata0", bus.m0_rdata_o, 0);

        // Timeout: gnt given, response never returns
        do_reset();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h300;
        step();
        bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        #1 check("t_gnt", 32'(bus.m0_gnt_o), 1);
        for (int k = 2; k <= 8; k++) begin
            step();
            bus.mem_gnt_i = 0;
            #1 check($sformatf("t_err%0d", k), 32'(bus.m0_err_o),
                     32'(k == 8));
            check($sformatf("t_rv%0d", k), 32'(bus.m0_rvalid_o), 0);
            check($sformatf("t_err1_%0d", k), 32'(bus.m1_err_o), 0);
        end
        step();
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h310;
        #1 check("t_idle_err", 32'(bus.m0_err_o), 0);
        check("t_idle_req", 32'(bus.mem_req_o), 0);
        step();
        bus.m1_req_i = 0;
        #1 check("t_next_req", 32'(bus.mem_req_o), 1);
        check("t_next_addr", bus.mem_addr_o, 32'h310);

        // Response on the timeout cycle wins
        do_reset();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h380;
        step();
        bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        for (int k = 2; k <= 8; k++) begin
            step();
            bus.mem_gnt_i = 0;
            if (k == 8) begin
                bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFE0001;
            end
        end
        #1 check("tr_rv", 32'(bus.m0_rvalid_o), 1);
        check("tr_err", 32'(bus.m0_err_o), 0);
        check("tr_rdata", bus.m0_rdata_o, 32'hCAFE0001);

        // Reset during RESP aborts; a late rvalid is ignored
        do_reset();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h400;
        step();
        bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        step();
        bus.mem_gnt_i = 0;
        rst = 1'b1;
        #1 check("ra_req", 32'(bus.mem_req_o), 0);
        check("ra_out", 32'({bus.m0_gnt_o, bus.m0_rvalid_o, bus.m0_err_o,
                             bus.m1_gnt_o, bus.m1_rvalid_o, bus.m1_err_o}), 0);
        step();
        rst = 1'b0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hBAD;
        #1 check("ra_late_rv0", 32'(bus.m0_rvalid_o), 0);
        check("ra_late_rv1", 32'(bus.m1_rvalid_o), 0);
        check("ra_late_rdata", bus.m0_rdata_o, 0);
        step();
        bus.mem_rvalid_i = 0;
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h404;
        step();
        bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        #1 check("ra_gnt", 32'(bus.m0_gnt_o), 1);
        check("ra_addr", bus.mem_addr_o, 32'h404);
        step();
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77;
        #1 check("ra_rv", 32'(bus.m0_rvalid_o), 1);
        check("ra_rdata", bus.m0_rdata_o, 32'h77);
        step();
        bus.mem_rvalid_i = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the cycles from entering REQ until a missing response is declared an error (range 2..65535).
REQ-002 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 arst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 mN_req_i  input  1  (N = 0, 1) SHALL be requester N's access request.
REQ-005 mN_we_i  input  1  SHALL be requester N's write enable: 1 = write, 0 = read.
REQ-006 mN_be_i  input  4  SHALL be requester N's byte enables.
REQ-007 mN_addr_i  input  32  SHALL be requester N's word address.
REQ-008 mN_wdata_i  input  32  SHALL be requester N's write data.
REQ-009 mN_gnt_o  output  1  SHALL pulse when memory accepts requester N's access.
REQ-010 mN_rvalid_o  output  1  SHALL be a one-cycle response pulse to requester N.
REQ-011 mN_rdata_o  output  32  SHALL carry response data to requester N.
REQ-012 mN_err_o  output  1  SHALL be a one-cycle timeout pulse to requester N.
REQ-013 mem_req_o, mem_we_o (1), mem_be_o (4), mem_addr_o (32), mem_wdata_o (32)  output  SHALL be the shared memory request port.
REQ-014 mem_gnt_i (1), mem_rvalid_i (1), mem_rdata_i (32)  input  SHALL be the shared memory acceptance and response.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ, RESP; exactly one access SHALL be outstanding at a time.
REQ-016 IDLE: if any mN_req_i=1, pick a winner and go to REQ next cycle.
REQ-017 Latch in the same edge: owner, we, be, addr, wdata.
REQ-018 Winner selection: a sole requester wins; if both request, the one not served last wins (round-robin).
REQ-019 REQ: mem_req_o=1; mem_we/be/addr/wdata_o SHALL come from the latched registers; requester input changes after latch SHALL be ignored.
REQ-020 REQ: mN_gnt_o = mem_gnt_i for the owner only, combinationally in the same cycle; on mem_gnt_i=1 go to RESP.
REQ-021 RESP: mem_req_o=0.
REQ-022 RESP, mem_rvalid_i=1: owner mN_rvalid_o=1 and mN_rdata_o=mem_rdata_i in that cycle; go to IDLE; set last-served to owner.
REQ-023 mN_rdata_o SHALL be 0 whenever mN_rvalid_o=0; the non-owner's gnt/rvalid/err/rdata outputs SHALL stay 0.
REQ-024 mem_gnt_i outside REQ and mem_rvalid_i outside RESP SHALL be ignored.
REQ-025 mem_addr/we/be/wdata_o SHALL be 0 outside REQ.
REQ-026 A 16-bit wait counter SHALL clear on entering REQ and increment each cycle in REQ or RESP.
REQ-027 If the counter reaches MAX_WAIT-1 without completion: owner mN_err_o=1 (rvalid stays 0) for one cycle; go to IDLE; set last-served to owner.
REQ-028 If completion and timeout fall in the same cycle, completion SHALL win and err SHALL stay 0.
REQ-029 Minimum transaction length SHALL be 3 cycles (IDLE, REQ, RESP), with at least one IDLE cycle between transactions.
REQ-030 Latency: mem_req_o SHALL rise one cycle after the winning mN_req_i is sampled in IDLE.

Reset
REQ-031 While arst_i=1: state=IDLE, owner=0, last-served=1 (m0 wins the first tie), counter=0, all outputs 0.
REQ-032 Reset in REQ or RESP SHALL abort the access with no gnt, rvalid or err to any requester; any later mem_rvalid_i SHALL be ignored.

Verification
REQ-033 m0 read addr 0x100, mem_gnt_i in the first REQ cycle, mem_rvalid_i with rdata 0xDEADBEEF two cycles later -> m0_gnt_o pulse, then m0_rvalid_o with 0xDEADBEEF; m1 outputs stay 0.
REQ-034 Both request continuously from reset -> grants alternate m0, m1, m0, m1; mem_addr_o matches each owner.
REQ-035 m1 write be=4'b1100 wdata=0x12345678; memory withholds gnt 3 cycles -> mem_req_o held 4 cycles with stable fields; m1_gnt_o pulses once.
REQ-036 MAX_WAIT=8, gnt given, rvalid never returns -> m0_err_o pulses 7 cycles after REQ entry; m0_rvalid_o stays 0; FSM returns to IDLE.
REQ-037 arst_i asserted in RESP, then mem_rvalid_i=1 after release -> no mN_rvalid_o; next m0 request completes normally.
REQ-038 rvalid on the timeout cycle -> rvalid delivered, err=0.
